adder_rr_arbiter: RTL and testbench
===================================

# adder_rr_arbiter

Round-robin arbiter and sequencer that shares one combinational W-bit adder among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, latches its operands, drives them to the shared adder, registers the sum, and returns it tagged with the requester index. It sits between the project's input muxing and the shared adder instance inside the top-level wrapper.

## Interface
- NREQ, 4: number of requesters (2..8)
- W, 8: operand/sum width
- IDW, 2: width of requester index, equal to clog2(NREQ)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  NREQ  per-requester request valid
- req_a  in  NREQ*W  operand A, requester i at bits [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing
- req_ready  out  NREQ  one-hot grant; combinational, only in IDLE
- adder_a  out  W  operand A to shared adder (registered)
- adder_b  out  W  operand B to shared adder (registered)
- adder_y  in  W  shared adder result; combinational in adder_a/adder_b
- res_valid  out  1  result valid
- res_id  out  IDW  index of the requester that owns the result
- res_sum  out  W  registered sum, modulo 2^W
- res_ready  in  1  downstream accepts result

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - Winner is the first asserted req_valid bit scanning upward from prio_ptr, wrapping modulo NREQ.
  - req_ready has exactly the winner bit set, and no bit if no req_valid.
  - On a grant: latch req_a/req_b of the winner into adder_a/adder_b, latch the winner into res_id, set prio_ptr = (winner+1) mod NREQ, go to CALC.
- CALC:
  - Capture adder_y into res_sum and go to DONE.
  - req_ready = 0.
- DONE:
  - res_valid = 1. res_id and res_sum are held stable.
  - When res_ready = 1, go to IDLE.
  - req_ready = 0.
- res_valid is 1 only in DONE.
- adder_a/adder_b/res_id/res_sum hold their values outside the capture cycles.
- Arithmetic: the carry-out is discarded, so 0xFF+0x01 = 0x00 at W=8.
- Requesters may drop req_valid or change operands at any time while not granted; only the values present in the grant cycle are used.
- A requester whose req_valid stays high is served again only after every other asserted requester has been served (no starvation).
- Reset (asynchronous, any state):
  - State to IDLE, prio_ptr = 0.
  - adder_a, adder_b, res_sum, res_id = 0.
  - res_valid = 0, req_ready = 0.
  - An in-flight request is dropped and not replayed.

## Timing
- Handshake accept in cycle T (req_valid[i] & req_ready[i] at a rising edge).
- adder_a/adder_b are valid from T+1.
- res_sum is registered at the end of T+1, so res_valid = 1 from cycle T+2: latency 2 cycles from accept to result.
- The result is held until res_ready is sampled high. With res_ready tied high, res_valid lasts exactly one cycle.
- Minimum request-to-request spacing is 3 cycles: the next grant is possible in the cycle after DONE exits.
- req_ready depends combinationally on req_valid and registered state only, never on res_ready, so there is no combinational loop.
- The block allows one outstanding transaction; there is no buffering beyond res_sum.

## Test plan
- Single request:
  - Stimulus: req_valid=0001, a0=0x12, b0=0x34, res_ready=1.
  - Response: req_ready=0001 for one cycle; res_valid 2 cycles later with res_sum=0x46, res_id=0.
- Wrap-around:
  - Stimulus: a1=0xFF, b1=0x01 on requester 1.
  - Response: res_sum=0x00, res_id=1.
- Round-robin fairness:
  - Stimulus: all four req_valid held high, res_ready=1.
  - Response: grants in order 0,1,2,3,0 with one grant every 3 cycles.
- Pointer skip:
  - Stimulus: after serving requester 2, assert req_valid=0101.
  - Response: grant goes to 0 (wrap past 3), then to 2.
- Backpressure:
  - Stimulus: res_ready=0 for 5 cycles in DONE, while requester inputs change.
  - Response: res_valid, res_sum and res_id stay stable; req_ready stays 0; exit to IDLE one cycle after res_ready=1.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously while in CALC.
  - Response: res_valid=0, res_sum=0, prio_ptr=0 immediately; after release, the first grant goes to the lowest asserted index.

Source files
------------

// File: rtl/adder_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// adder_rr_arbiter_if
//
// Bundles the requester handshake, the shared-adder operand/result path and
// the result handshake of adder_rr_arbiter.
//
//   req_valid [NREQ]    per-requester request valid
//   req_a     [NREQ*W]  operand A, requester i at bits [i*W +: W]
//   req_b     [NREQ*W]  operand B, same packing
//   req_ready [NREQ]    one-hot grant from the arbiter
//   adder_a   [W]       registered operand A to the shared adder
//   adder_b   [W]       registered operand B to the shared adder
//   adder_y   [W]       shared adder result (combinational in adder_a/b)
//   res_valid           result valid
//   res_id    [IDW]     index of the requester owning the result
//   res_sum   [W]       registered sum, modulo 2^W
//   res_ready           downstream accepts result
//
// slave  : the arbiter side
// master : the requesters / adder / result consumer side
// ---------------------------------------------------------------------------
interface adder_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      adder_a;
    logic [W-1:0]      adder_b;
    logic [W-1:0]      adder_y;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [W-1:0]      res_sum;
    logic              res_ready;

    modport slave (
        input  req_valid, req_a, req_b, adder_y, res_ready,
        output req_ready, adder_a, adder_b, res_valid, res_id, res_sum
    );

    modport master (
        output req_valid, req_a, req_b, adder_y, res_ready,
        input  req_ready, adder_a, adder_b, res_valid, res_id, res_sum
    );
endinterface

// File: rtl/adder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// adder_rr_arbiter
//
// Shares one combinational W-bit adder among NREQ requesters. One requester
// is granted at a time (round-robin), its operands are registered onto the
// adder inputs, the adder output is registered as the sum and returned with
// the requester index. One transaction is outstanding at a time.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    adder_rr_arbiter_if.slave (request, adder and result signals)
//
// Timing: accept in cycle T, adder operands valid from T+1, result valid
// from T+2 and held until res_ready is sampled high.
// ---------------------------------------------------------------------------
module adder_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    adder_rr_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] prio_ptr_q, prio_ptr_d;
    logic [W-1:0]   adder_a_q, adder_a_d;
    logic [W-1:0]   adder_b_q, adder_b_d;
    logic [W-1:0]   res_sum_q, res_sum_d;
    logic [IDW-1:0] res_id_q, res_id_d;

    logic           found;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] idx;
    logic [NREQ-1:0] grant_vec;

    // Round-robin search: first asserted request at or above prio_ptr,
    // wrapping back to index 0.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(prio_ptr_q) + k) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        prio_ptr_d = prio_ptr_q;
        adder_a_d  = adder_a_q;
        adder_b_d  = adder_b_q;
        res_sum_d  = res_sum_q;
        res_id_d   = res_id_q;
        grant_vec  = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_vec[winner] = 1'b1;
                    for (int i = 0; i < NREQ; i++) begin
                        if (IDW'(i) == winner) begin
                            adder_a_d = bus.req_a[i*W +: W];
                            adder_b_d = bus.req_b[i*W +: W];
                        end
                    end
                    res_id_d   = winner;
                    prio_ptr_d = IDW'((int'(winner) + 1) % NREQ);
                    state_d    = CALC;
                end
            end
            CALC: begin
                // Carry-out of the shared adder is simply not captured.
                res_sum_d = bus.adder_y;
                state_d   = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prio_ptr_q <= '0;
            adder_a_q  <= '0;
            adder_b_q  <= '0;
            res_sum_q  <= '0;
            res_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            prio_ptr_q <= prio_ptr_d;
            adder_a_q  <= adder_a_d;
            adder_b_q  <= adder_b_d;
            res_sum_q  <= res_sum_d;
            res_id_q   <= res_id_d;
        end
    end

    // The grant is suppressed while reset is held so nothing is accepted
    // during reset even though the state register already reads IDLE.
    assign bus.req_ready = rst_n ? grant_vec : '0;
    assign bus.adder_a   = adder_a_q;
    assign bus.adder_b   = adder_b_q;
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_id    = res_id_q;
    assign bus.res_sum   = res_sum_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_rr_arbiter
//
// Directed scenarios plus a randomized run checked against a transaction
// level reference model of the arbiter.
// ---------------------------------------------------------------------------
module tb_adder_rr_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [W-1:0] a_in [NREQ];
    logic [W-1:0] b_in [NREQ];

    adder_rr_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

    // Behaviour of the shared adder the block drives.
    assign bus.adder_y = bus.adder_a + bus.adder_b;

    adder_rr_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[i] = a;
        b_in[i] = b;
        bus.req_a = {a_in[3], a_in[2], a_in[1], a_in[0]};
        bus.req_b = {b_in[3], b_in[2], b_in[1], b_in[0]};
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus.req_valid = 4'b1111;
        bus.res_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b exp 0000", bus.req_ready); end
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b exp 0", bus.res_valid); end
        n_checks++; if (bus.adder_a !== 8'h00 || bus.adder_b !== 8'h00) begin n_fail++; $display("FAIL reset_adder got %h/%h exp 00/00", bus.adder_a, bus.adder_b); end
        n_checks++; if (bus.res_sum !== 8'h00 || bus.res_id !== 2'd0) begin n_fail++; $display("FAIL reset_result got %h id %0d exp 00 id 0", bus.res_sum, bus.res_id); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got %b exp 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
    endtask

    task automatic test_single();
        apply_reset();
        @(negedge clk);
        bus.req_valid = 4'b0001; set_op(0, 8'h12, 8'h34); bus.res_ready = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant got %b exp 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0000 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL single_calc ready %b valid %b exp 0000 0", bus.req_ready, bus.res_valid); end
        n_checks++; if (bus.adder_a !== 8'h12 || bus.adder_b !== 8'h34) begin n_fail++; $display("FAIL single_operands got %h/%h exp 12/34", bus.adder_a, bus.adder_b); end
        @(negedge clk); #1;
        n_checks++; if (bus.res_valid !== 1'b1 || bus.res_sum !== 8'h46 || bus.res_id !== 2'd0) begin n_fail++; $display("FAIL single_result valid %b sum %h id %0d exp 1 46 0", bus.res_valid, bus.res_sum, bus.res_id); end
        @(negedge clk); #1;
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_one_cycle got %b exp 0", bus.res_valid); end
    endtask

    task automatic test_wrap();
        apply_reset();
        @(negedge clk);
        bus.req_valid = 4'b0010; set_op(1, 8'hFF, 8'h01); bus.res_ready = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_grant got %b exp 0010", bus.req_ready); end
        @(negedge clk); bus.req_valid = '0;
        @(negedge clk); #1;
        n_checks++; if (bus.res_valid !== 1'b1 || bus.res_sum !== 8'h00 || bus.res_id !== 2'd1) begin n_fail++; $display("FAIL wrap_result valid %b sum %h id %0d exp 1 00 1", bus.res_valid, bus.res_sum, bus.res_id); end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] eh;
        logic [W-1:0] es;
        int e;
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_op(i, 8'($urandom), 8'($urandom));
        bus.req_valid = 4'b1111; bus.res_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            e = g % NREQ;
            eh = 4'(1) << e;
            es = a_in[e] + b_in[e];
            if (g != 0) @(negedge clk);
            #1;
            n_checks++; if (bus.req_ready !== eh) begin n_fail++; $display("FAIL fair_grant%0d got %b exp %b", g, bus.req_ready, eh); end
            @(negedge clk); #1;
            n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL fair_calc_ready%0d got %b exp 0000", g, bus.req_ready); end
            @(negedge clk); #1;
            n_checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(e) || bus.res_sum !== es) begin n_fail++; $display("FAIL fair_result%0d valid %b id %0d sum %h exp 1 %0d %h", g, bus.res_valid, bus.res_id, bus.res_sum, e, es); end
        end
        @(negedge clk); bus.req_valid = '0;
    endtask

    task automatic test_pointer_skip();
        apply_reset();
        @(negedge clk);
        bus.req_valid = 4'b0100; set_op(2, 8'h07, 8'h08); set_op(0, 8'h30, 8'h03); bus.res_ready = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL skip_first got %b exp 0100", bus.req_ready); end
        @(negedge clk); bus.req_valid = '0;
        @(negedge clk); #1;
        n_checks++; if (bus.res_id !== 2'd2 || bus.res_sum !== 8'h0F) begin n_fail++; $display("FAIL skip_first_result id %0d sum %h exp 2 0f", bus.res_id, bus.res_sum); end
        @(negedge clk);
        bus.req_valid = 4'b0101;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL skip_wrap got %b exp 0001", bus.req_ready); end
        @(negedge clk);
        @(negedge clk); #1;
        n_checks++; if (bus.res_id !== 2'd0 || bus.res_sum !== 8'h33) begin n_fail++; $display("FAIL skip_wrap_result id %0d sum %h exp 0 33", bus.res_id, bus.res_sum); end
        @(negedge clk); #1;
        n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL skip_next got %b exp 0100", bus.req_ready); end
        @(negedge clk); bus.req_valid = '0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        @(negedge clk);
        bus.req_valid = 4'b0001; set_op(0, 8'h21, 8'h42); bus.res_ready = 1'b0;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_grant got %b exp 0001", bus.req_ready); end
        @(negedge clk); bus.req_valid = 4'($urandom);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.req_valid = 4'($urandom);
            for (int i = 0; i < NREQ; i++) set_op(i, 8'($urandom), 8'($urandom));
            #1;
            n_checks++; if (bus.res_valid !== 1'b1 || bus.res_sum !== 8'h63 || bus.res_id !== 2'd0) begin n_fail++; $display("FAIL bp_hold%0d valid %b sum %h id %0d exp 1 63 0", c, bus.res_valid, bus.res_sum, bus.res_id); end
            n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d got %b exp 0000", c, bus.req_ready); end
        end
        @(negedge clk);
        bus.res_ready = 1'b1; bus.req_valid = 4'b1000;
        #1;
        n_checks++; if (bus.res_valid !== 1'b1 || bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_release valid %b ready %b exp 1 0000", bus.res_valid, bus.req_ready); end
        @(negedge clk);
        bus.res_ready = 1'b0;
        #1;
        n_checks++; if (bus.res_valid !== 1'b0 || bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_exit valid %b ready %b exp 0 1000", bus.res_valid, bus.req_ready); end
        @(negedge clk); bus.req_valid = '0; bus.res_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        @(negedge clk);
        bus.req_valid = 4'b0100; set_op(2, 8'h10, 8'h20); bus.res_ready = 1'b1;
        @(negedge clk); bus.req_valid = '0;
        @(negedge clk); #1;
        n_checks++; if (bus.res_sum !== 8'h30 || bus.res_id !== 2'd2) begin n_fail++; $display("FAIL mid_setup sum %h id %0d exp 30 2", bus.res_sum, bus.res_id); end
        @(negedge clk);
        bus.req_valid = 4'b0010; set_op(1, 8'h05, 8'h06);
        #1;
        n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_grant got %b exp 0010", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'b0110;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.res_valid !== 1'b0 || bus.res_sum !== 8'h00 || bus.res_id !== 2'd0) begin n_fail++; $display("FAIL mid_reset_result valid %b sum %h id %0d exp 0 00 0", bus.res_valid, bus.res_sum, bus.res_id); end
        n_checks++; if (bus.adder_a !== 8'h00 || bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_ctrl adder_a %h ready %b exp 00 0000", bus.adder_a, bus.req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_first_grant got %b exp 0010", bus.req_ready); end
        @(negedge clk); bus.req_valid = '0;
        @(negedge clk); #1;
        n_checks++; if (bus.res_valid !== 1'b1 || bus.res_sum !== 8'h0B || bus.res_id !== 2'd1) begin n_fail++; $display("FAIL mid_after_result valid %b sum %h id %0d exp 1 0b 1", bus.res_valid, bus.res_sum, bus.res_id); end
    endtask

    task automatic test_random();
        int ptr, w, age, eid;
        bit busy;
        logic [W-1:0] ea, eb, es;
        logic [NREQ-1:0] v, eh;
        apply_reset();
        ptr = 0; busy = 0; age = 0; eid = 0; ea = '0; eb = '0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            v = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
            bus.req_valid = v;
            for (int i = 0; i < NREQ; i++) set_op(i, 8'($urandom), 8'($urandom));
            bus.res_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (!busy) begin
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && ((v >> ((ptr + k) % NREQ)) & 4'd1) != 0) w = (ptr + k) % NREQ;
                end
                eh = (w < 0) ? 4'b0000 : (4'(1) << w);
                n_checks++; if (bus.req_ready !== eh || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rand_idle c%0d ready %b valid %b exp %b 0", c, bus.req_ready, bus.res_valid, eh); end
                if (w >= 0) begin
                    busy = 1; age = 0; eid = w; ea = a_in[w]; eb = b_in[w];
                    ptr = (w + 1) % NREQ;
                end
            end else begin
                age++;
                n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rand_busy_ready c%0d got %b exp 0000", c, bus.req_ready); end
                if (age == 1) begin
                    n_checks++; if (bus.res_valid !== 1'b0 || bus.adder_a !== ea || bus.adder_b !== eb) begin n_fail++; $display("FAIL rand_calc c%0d valid %b a %h b %h exp 0 %h %h", c, bus.res_valid, bus.adder_a, bus.adder_b, ea, eb); end
                end else begin
                    es = ea + eb;
                    n_checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(eid) || bus.res_sum !== es) begin n_fail++; $display("FAIL rand_result c%0d valid %b id %0d sum %h exp 1 %0d %h", c, bus.res_valid, bus.res_id, bus.res_sum, eid, es); end
                    if (bus.res_ready) busy = 0;
                end
            end
        end
        @(negedge clk); bus.req_valid = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_wrap();
        test_fairness();
        test_pointer_skip();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
